// File: rtl/hwag_angle_channel.sv
// Angle-driven output channel: drives `out` high between a programmed set
// angle and reset angle of the synchronised angle count, with an optional
// on-time limit. Angle pairs are double-buffered and only become active in
// IDLE or on the wrapping step while ARMED.
module hwag_angle_channel #(
  parameter int ANGLE_WIDTH = 24,
  parameter int ANGLE_TOP   = 3839,
  parameter int ONCNT_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hwag_start,
  input  logic [ANGLE_WIDTH-1:0] acnt,
  input  logic                   ena,
  input  logic                   wr,
  input  logic [ANGLE_WIDTH-1:0] wr_set,
  input  logic [ANGLE_WIDTH-1:0] wr_rst,
  input  logic [ONCNT_WIDTH-1:0] max_on,
  input  logic                   flag_clr,
  output logic                   out,
  output logic                   busy,
  output logic                   flag_tmo,
  output logic                   flag_miss
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_ON    = 2'd2;

  localparam logic [ANGLE_WIDTH-1:0] TOP = ANGLE_WIDTH'(ANGLE_TOP);
  localparam logic [ONCNT_WIDTH-1:0] ONE = ONCNT_WIDTH'(1);

  logic [1:0]             state_q,     state_d;
  logic                   out_q,       out_d;
  logic                   tmo_q,       tmo_d;
  logic                   miss_q,      miss_d;
  logic [ANGLE_WIDTH-1:0] act_set_q,   act_set_d;
  logic [ANGLE_WIDTH-1:0] act_rst_q,   act_rst_d;
  logic [ANGLE_WIDTH-1:0] pend_set_q,  pend_set_d;
  logic [ANGLE_WIDTH-1:0] pend_rst_q,  pend_rst_d;
  logic                   pend_vld_q,  pend_vld_d;
  logic [ANGLE_WIDTH-1:0] prev_acnt_q, prev_acnt_d;
  logic                   start_prev_q, start_prev_d;
  logic [ONCNT_WIDTH-1:0] oncnt_q,     oncnt_d;

  logic step, wrap, cross_set, cross_rst, xfer, tmo_hit, tmo_set, miss_set;

  // Half-open interval (p, c] modulo ANGLE_TOP+1. In the wrapping case the
  // upper part is bounded by TOP so out-of-range angles are never crossed.
  function automatic logic crossed(input logic [ANGLE_WIDTH-1:0] t,
                                   input logic [ANGLE_WIDTH-1:0] p,
                                   input logic [ANGLE_WIDTH-1:0] c);
    if (c > p) crossed = (t > p) && (t <= c);
    else       crossed = ((t > p) && (t <= TOP)) || (t <= c);
  endfunction

  // Step detection, crossing decode, shadow transfer, FSM and flag updates
  always_comb begin
    step      = hwag_start && start_prev_q && (acnt != prev_acnt_q);
    wrap      = acnt < prev_acnt_q;
    cross_set = step && crossed(act_set_q, prev_acnt_q, acnt);
    cross_rst = step && crossed(act_rst_q, prev_acnt_q, acnt);
    tmo_hit   = (max_on != '0) && (oncnt_q == (max_on - ONE));
    xfer      = pend_vld_q && ((state_q == S_IDLE) ||
                               ((state_q == S_ARMED) && step && wrap));

    state_d      = state_q;
    act_set_d    = act_set_q;
    act_rst_d    = act_rst_q;
    pend_set_d   = pend_set_q;
    pend_rst_d   = pend_rst_q;
    pend_vld_d   = pend_vld_q;
    prev_acnt_d  = hwag_start ? acnt : prev_acnt_q;
    start_prev_d = hwag_start;
    tmo_set      = 1'b0;
    miss_set     = 1'b0;

    // On-time counter runs only in ON and saturates
    oncnt_d = oncnt_q;
    if ((state_q == S_ON) && (oncnt_q != '1)) oncnt_d = oncnt_q + ONE;

    // Transfer consumes the old pending pair before a same-cycle write refills it
    if (xfer) begin
      act_set_d  = pend_set_q;
      act_rst_d  = pend_rst_q;
      pend_vld_d = 1'b0;
    end
    if (wr) begin
      pend_set_d = wr_set;
      pend_rst_d = wr_rst;
      pend_vld_d = 1'b1;
    end

    if (!ena || !hwag_start) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_ARMED;
        S_ARMED: begin
          if (cross_set && cross_rst) begin
            miss_set = 1'b1;
          end else if (cross_set) begin
            state_d = S_ON;
            oncnt_d = '0;
          end
        end
        S_ON: begin
          if (cross_rst) begin
            state_d = S_ARMED;
          end else if (tmo_hit) begin
            state_d = S_ARMED;
            tmo_set = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    out_d  = (state_d == S_ON);
    tmo_d  = (tmo_q  && !flag_clr) || tmo_set;
    miss_d = (miss_q && !flag_clr) || miss_set;
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      out_q        <= 1'b0;
      tmo_q        <= 1'b0;
      miss_q       <= 1'b0;
      act_set_q    <= '0;
      act_rst_q    <= '0;
      pend_set_q   <= '0;
      pend_rst_q   <= '0;
      pend_vld_q   <= 1'b0;
      prev_acnt_q  <= '0;
      start_prev_q <= 1'b0;
      oncnt_q      <= '0;
    end else begin
      state_q      <= state_d;
      out_q        <= out_d;
      tmo_q        <= tmo_d;
      miss_q       <= miss_d;
      act_set_q    <= act_set_d;
      act_rst_q    <= act_rst_d;
      pend_set_q   <= pend_set_d;
      pend_rst_q   <= pend_rst_d;
      pend_vld_q   <= pend_vld_d;
      prev_acnt_q  <= prev_acnt_d;
      start_prev_q <= start_prev_d;
      oncnt_q      <= oncnt_d;
    end
  end

  assign out       = out_q;
  assign busy      = (state_q == S_ON);
  assign flag_tmo  = tmo_q;
  assign flag_miss = miss_q;

endmodule

// File: tb/tb_hwag_angle_channel.sv
// Directed bench for hwag_angle_channel: each angle step pushes the expected
// output level to a queue, which is popped and compared after the edge.
module tb_hwag_angle_channel;

  logic        clk = 1'b0;
  logic        rst;
  logic        hwag_start;
  logic [23:0] acnt;
  logic        ena;
  logic        wr;
  logic [23:0] wr_set;
  logic [23:0] wr_rst;
  logic [23:0] max_on;
  logic        flag_clr;
  logic        out;
  logic        busy;
  logic        flag_tmo;
  logic        flag_miss;

  int n_assert = 0;
  int n_fail   = 0;
  bit exp_q[$];

  hwag_angle_channel #(
    .ANGLE_WIDTH(24),
    .ANGLE_TOP  (3839),
    .ONCNT_WIDTH(24)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .hwag_start(hwag_start),
    .acnt      (acnt),
    .ena       (ena),
    .wr        (wr),
    .wr_set    (wr_set),
    .wr_rst    (wr_rst),
    .max_on    (max_on),
    .flag_clr  (flag_clr),
    .out       (out),
    .busy      (busy),
    .flag_tmo  (flag_tmo),
    .flag_miss (flag_miss)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic e);
    n_assert++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, e);
    end
  endtask

  // Expected output window for a set/reset pair, including the wrapped case
  function automatic bit in_win(input int a, input int s, input int r);
    if (s < r) return (a >= s) && (a < r);
    else       return (a >= s) || (a < r);
  endfunction

  task automatic step(input int a, input bit e);
    bit eo;
    @(negedge clk);
    acnt = 24'(a);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    eo = exp_q.pop_front();
    chk($sformatf("out@%0d", a), out, eo);
    chk($sformatf("busy@%0d", a), busy, eo);
  endtask

  task automatic sweep(input int lo, input int hi, input int s, input int r);
    for (int a = lo; a <= hi; a++) step(a, in_win(a, s, r));
  endtask

  // Drop sync to force IDLE (loading a new pair), then re-arm at the same angle
  task automatic resync(input int a, input int s, input int r);
    hwag_start = 1'b0;
    wr = 1'b1;
    wr_set = 24'(s);
    wr_rst = 24'(r);
    step(a, 1'b0);
    wr = 1'b0;
    hwag_start = 1'b1;
    step(a, 1'b0);
  endtask

  initial begin
    rst = 1'b1; hwag_start = 1'b0; acnt = '0; ena = 1'b0; wr = 1'b0;
    wr_set = '0; wr_rst = '0; max_on = '0; flag_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", out, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_tmo", flag_tmo, 1'b0);
    chk("rst_miss", flag_miss, 1'b0);
    rst = 1'b0;

    // Basic pulse 100..300
    wr = 1'b1; wr_set = 24'd100; wr_rst = 24'd300;
    step(0, 1'b0);
    wr = 1'b0; ena = 1'b1; hwag_start = 1'b1;
    step(0, 1'b0);
    sweep(1, 3839, 100, 300);
    step(0, 1'b0);
    chk("basic_tmo", flag_tmo, 1'b0);
    chk("basic_miss", flag_miss, 1'b0);

    // Write while ARMED: old pair stays until the wrap, then wrap pulse 3800..50
    wr = 1'b1; wr_set = 24'd3800; wr_rst = 24'd50;
    step(0, 1'b0);
    wr = 1'b0;
    sweep(1, 3839, 100, 300);
    step(0, 1'b0);
    step(50, 1'b0);
    sweep(51, 3839, 3800, 50);
    sweep(0, 60, 3800, 50);

    // Jump across set
    resync(60, 150, 300);
    step(120, 1'b0);
    step(192, 1'b1);
    step(250, 1'b1);
    step(300, 1'b0);

    // Jump across both, then clear
    resync(128, 150, 180);
    step(192, 1'b0);
    chk("miss_both", flag_miss, 1'b1);
    flag_clr = 1'b1;
    step(200, 1'b0);
    flag_clr = 1'b0;
    chk("miss_clr", flag_miss, 1'b0);

    // set == rst, with flag_clr on the same edge: the set wins
    resync(128, 200, 200);
    flag_clr = 1'b1;
    step(250, 1'b0);
    flag_clr = 1'b0;
    chk("miss_eq_clr", flag_miss, 1'b1);
    flag_clr = 1'b1;
    step(260, 1'b0);
    flag_clr = 1'b0;
    chk("miss_eq_clr2", flag_miss, 1'b0);

    // Timeout after exactly 50 cycles
    max_on = 24'd50;
    resync(0, 100, 3000);
    for (int a = 1; a <= 200; a++) step(a, (a >= 100) && (a < 150));
    chk("tmo_set", flag_tmo, 1'b1);

    // Reset angle and timeout coincide: reset angle wins, no tmo flag
    flag_clr = 1'b1;
    max_on = 24'd20;
    resync(0, 100, 120);
    flag_clr = 1'b0;
    chk("tmo_cleared", flag_tmo, 1'b0);
    for (int a = 1; a <= 130; a++) step(a, (a >= 100) && (a < 120));
    chk("tmo_tie", flag_tmo, 1'b0);
    max_on = 24'd0;

    // Sync loss mid-pulse
    resync(0, 100, 300);
    for (int a = 1; a <= 150; a++) step(a, a >= 100);
    hwag_start = 1'b0;
    step(151, 1'b0);
    hwag_start = 1'b1;
    step(152, 1'b0);
    step(200, 1'b0);
    step(400, 1'b0);

    // Write during ON: current pulse keeps old rst, new pair after next wrap
    resync(0, 100, 300);
    for (int a = 1; a <= 150; a++) step(a, a >= 100);
    wr = 1'b1; wr_set = 24'd500; wr_rst = 24'd600;
    step(151, 1'b1);
    wr = 1'b0;
    sweep(152, 3839, 100, 300);
    step(0, 1'b0);
    sweep(1, 700, 500, 600);
    chk("end_tmo", flag_tmo, 1'b0);
    chk("end_miss", flag_miss, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hwag_angle_channel.md
Name: hwag_angle_channel

Overview:
- Angle-driven output channel directly downstream of the angle generator.
- Consumes the synchronised angle count (0..ANGLE_TOP, 64 ticks per tooth) and the generator-running flag.
- Drives one output (coil dwell / injector) high between a programmed set angle and reset angle, with an on-time limit.
- Angle pairs are double-buffered so that software writes take effect only at a safe point.

Parameters:
- ANGLE_WIDTH, 24, width of the angle bus and angle registers.
- ANGLE_TOP, 3839, last angle value; the count wraps from ANGLE_TOP to 0.
- ONCNT_WIDTH, 24, width of the on-time limit counter.

Ports:
- clk  in  1  module clock.
- rst  in  1  synchronous reset, active-high.
- hwag_start  in  1  angle generator synchronised; acnt is valid only while high.
- acnt  in  ANGLE_WIDTH  current angle from the generator.
- ena  in  1  channel enable.
- wr  in  1  one-cycle write strobe for the pending angle pair.
- wr_set  in  ANGLE_WIDTH  pending set (output-on) angle.
- wr_rst  in  ANGLE_WIDTH  pending reset (output-off) angle.
- max_on  in  ONCNT_WIDTH  on-time limit in clk cycles; 0 disables the limit.
- flag_clr  in  1  clears the sticky flags.
- out  out  1  channel output, registered.
- busy  out  1  high while in ON.
- flag_tmo  out  1  sticky: pulse was ended by the on-time limit.
- flag_miss  out  1  sticky: set and reset crossed in the same step.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out, busy, flag_tmo and flag_miss go to 0.
  - State goes to IDLE.
  - Active and pending set/reset registers go to 0; pending-valid goes to 0.
  - prev_acnt goes to 0; the on-time counter goes to 0.
- Write path:
  - wr=1 latches wr_set and wr_rst into the pending registers and sets pending-valid.
  - A new wr overwrites any unconsumed pending pair.
  - Writes of values above ANGLE_TOP are stored unchanged; they can never be crossed, so the channel stays ARMED.
- Step and crossing:
  - prev_acnt <= acnt every cycle while hwag_start=1.
  - A step occurs when hwag_start=1, the previous cycle also had hwag_start=1, and acnt != prev_acnt.
  - crossed(t) is true in a step when t lies in the half-open interval (prev_acnt, acnt], computed modulo ANGLE_TOP+1.
  - Non-wrapping step (acnt > prev_acnt): crossed(t) = prev_acnt < t <= acnt.
  - Wrapping step (acnt < prev_acnt): crossed(t) = t > prev_acnt or t <= acnt.
  - Multi-tick jumps, caused by the generator reloading at a tooth edge, therefore never miss an event.
- Shadow transfer: pending moves to active and pending-valid clears when either holds:
  - state is IDLE, or
  - state is ARMED and the step is a wrapping step.
- State machine (registered; out = 1 only in ON):
  - IDLE → ARMED: when ena=1 and hwag_start=1. The shadow transfer happens on the same edge.
  - ARMED → ON: on a step with crossed(set) and not crossed(rst). out=1 from the next cycle, giving 1-cycle latency from the acnt step. The on-time counter clears.
  - ARMED, with crossed(set) and crossed(rst) in the same step: stay ARMED, no pulse, flag_miss set. This includes set == rst.
  - ON → ARMED on crossed(rst); out returns to 0 on the next cycle.
  - ON → ARMED when max_on != 0 and the on-time counter reaches max_on - 1. Pulse width is exactly max_on cycles; flag_tmo is set.
  - If crossed(rst) and the timeout occur together, the reset-angle ending wins and flag_tmo is not set.
  - Any state → IDLE when ena=0 or hwag_start=0. out drops on the next cycle. Sticky flags are kept. The state re-arms only when hwag_start returns.
  - The on-time counter increments only in ON and saturates at all-ones.
- Flags:
  - flag_clr clears both flags.
  - If flag_clr coincides with a new set condition, the set wins.
- Writes while in ON do not affect the current pulse. Transfer is deferred to the first wrapping step in ARMED.

Test Plan:
- Basic pulse: write set=100, rst=300; step acnt 0..3839 once per cycle → out high from the cycle after acnt=100 until the cycle after acnt=300, i.e. 200 cycles; flags stay 0.
- Wrap pulse: write set=3800, rst=50 → out rises after 3800, stays high across the 3839→0 wrap, falls after 50.
- Jump across set: acnt jumps 120→192 with set=150 → out rises the cycle after the jump.
- Jump across both: set=150, rst=180, acnt jumps 128→192 → no pulse and flag_miss=1. Then flag_clr → flag_miss=0.
- Timeout: set=100, rst=3000, max_on=50, slow acnt → out high exactly 50 cycles and flag_tmo=1.
- Sync loss and shadowing:
  - hwag_start drops mid-pulse → out=0 on the next cycle and state IDLE.
  - A write of set=500, rst=600 during ON → the current pulse still ends at the old rst; the new angles take effect only after the next wrap.
